toilet_core_param: RTL and testbench
====================================

Name: toilet_core_param

Overview:
- Parametrised next-generation sequencing core for the smart toilet controller.
- Runs the READY / USING / SPRAYING / DRYING / DISCHARGE session flow from the register-file control bits.
- New over the previous core: per-mode spray durations, selectable small/large discharge volume, manual flush request, and user-leave abort.
- Durations are set by parameters and counted by one shared counter. The core sits between the register block and the actuator drivers.

Parameters:
- CNT_W, 16, width of the shared duration counter.
- MODE_W, 2, width of reg_spray_mode; the mode count is 2**MODE_W.
- SPRAY_BASE, 100, spray cycles for mode 0; mode m lasts SPRAY_BASE*(m+1) cycles.
- DRY_CYC, 80, drying duration in cycles.
- DIS_SMALL, 40, discharge cycles when the latched de_ur is 0.
- DIS_LARGE, 60, discharge cycles when the latched de_ur is 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reg_user_en  in  1  user detected at the toilet.
- reg_toilet_using  in  1  user seated.
- reg_spray_en  in  1  spray request (level).
- reg_sp_dr_auto_en  in  1  drying follows spraying automatically.
- reg_spray_mode  in  MODE_W  spray intensity/duration select.
- reg_auto_dis_en  in  1  automatic discharge when the user leaves.
- reg_de_ur  in  1  discharge volume select (1 = large).
- reg_flush_req  in  1  manual flush request.
- warm_en  in  1  seat heating enable.
- warm_up_on  out  1  seat heater drive.
- open_toilet_lid  out  1  lid actuator.
- led_using  out  1  in-use indicator.
- spray_an  out  1  spray actuator.
- user_flushes  out  1  flush valve.
- dis_de  out  1  large-volume discharge select.
- count_spray_done  out  1  one-cycle pulse at spray completion.
- count_drying_done  out  1  one-cycle pulse at drying completion.
- count_dis_done  out  1  one-cycle pulse at discharge completion.
- stt_ready, stt_using, stt_spraying, stt_drying, stt_discharge  out  1 each  one-hot state flags.
- cnt_val  out  CNT_W  current counter value, for debug.

Behaviour:
- Reset (async, any state, including mid-spray or mid-discharge): state READY, cnt_val=0, de_ur latch=0, every output 0 except stt_ready=1.
- All outputs are registered or decoded from the registered state. Transitions take effect 1 cycle after the qualifying input is sampled.
- Counter behaviour:
  - Cleared to 0 on every state entry; increments by 1 each cycle while in SPRAYING, DRYING or DISCHARGE.
  - Done condition: cnt_val == DUR-1. In that cycle the matching count_*_done pulses high, the state transitions at the following edge, and the counter clears.
- READY:
  - open_toilet_lid = reg_user_en.
  - Goes to USING when reg_user_en && reg_toilet_using.
- USING, priority high to low:
  1. !reg_user_en -> DISCHARGE if reg_auto_dis_en, else READY.
  2. reg_spray_en -> SPRAYING; reg_spray_mode is latched on entry.
  3. reg_flush_req -> DISCHARGE.
  4. !reg_toilet_using && reg_auto_dis_en -> DISCHARGE.
  5. Otherwise stay.
- SPRAYING:
  - DUR = SPRAY_BASE*(latched mode+1), computed in CNT_W bits.
  - Done -> DRYING if reg_sp_dr_auto_en, else USING.
  - reg_spray_en falling before done -> USING, with no done pulse.
  - !reg_user_en -> same exit as USING rule 1; this takes priority over done.
- DRYING:
  - DUR = DRY_CYC. Done -> USING.
  - !reg_user_en -> USING rule 1 exit. reg_spray_en has no effect here.
- DISCHARGE:
  - reg_de_ur is latched on entry; DUR = DIS_LARGE if the latch is 1, else DIS_SMALL.
  - Not abortable; all inputs except reset are ignored.
  - Done -> READY if !reg_user_en, else USING.
- Output decode:
  - spray_an = stt_spraying.
  - user_flushes = stt_discharge.
  - dis_de = stt_discharge && de_ur latch.
  - led_using = !stt_ready.
  - open_toilet_lid = 1 in all states except READY, where it follows reg_user_en.
  - warm_up_on = warm_en && (USING|SPRAYING|DRYING).
- Elaboration check: the largest DUR must fit in CNT_W bits, and every DUR must be >= 1.

Decomposition:
- Shared package toilet_pkg holds:
  - the state encoding (5 one-hot localparams);
  - the default duration constants;
  - the duration-select function, which maps state, mode and de_ur to DUR.
- Sub-module toilet_dur_timer: counter with clear, enable, DUR input and done output, width CNT_W. It is reused for future timed actuators.

Test Plan:
- Basic session: reset; user_en=1, then toilet_using=1 after 5 cycles -> stt_using 1 cycle later.
  - Set spray_en=1, mode=0 -> spray_an high for exactly 100 cycles and count_spray_done pulses once.
  - Then drying lasts 80 cycles -> count_drying_done pulse, state USING.
- Mode scaling: mode=3 -> spray_an high for 400 cycles.
- Spray abort: spray_en drops at cycle 30 -> USING next cycle, no count_spray_done pulse.
  - Repeat with sp_dr_auto_en=0 and spray_en held -> USING after 100 cycles, no drying.
- User leaves with de_ur=1, auto_dis_en=1 -> DISCHARGE.
  - user_flushes=1 and dis_de=1 for 60 cycles, count_dis_done pulses, state READY.
  - With de_ur=0 the discharge lasts 40 cycles.
  - Toggling de_ur mid-discharge does not change the duration.
- Manual flush in USING with auto_dis_en=0 -> 40-cycle discharge, then USING.
  - Leaving with auto_dis_en=0 -> READY directly with no flush.
- Async reset asserted mid-DISCHARGE (cycle 20), not aligned to clk -> all outputs 0 and stt_ready=1 immediately.
  - After release the core stays in READY until user_en is asserted.

Source files
------------

// File: rtl/toilet_pkg.sv
// Shared definitions for the toilet sequencing core: one-hot state encoding,
// default durations and the state-to-duration mapping.
package toilet_pkg;

   typedef logic [4:0] state_t;

   localparam state_t ST_READY     = 5'b00001;
   localparam state_t ST_USING     = 5'b00010;
   localparam state_t ST_SPRAYING  = 5'b00100;
   localparam state_t ST_DRYING    = 5'b01000;
   localparam state_t ST_DISCHARGE = 5'b10000;

   localparam int unsigned DEF_SPRAY_BASE = 100;
   localparam int unsigned DEF_DRY_CYC    = 80;
   localparam int unsigned DEF_DIS_SMALL  = 40;
   localparam int unsigned DEF_DIS_LARGE  = 60;

   // Untimed states report 1 so a stray compare can never underflow.
   function automatic int unsigned dur_sel(
      input state_t      st,
      input int unsigned mode,
      input logic        de_ur,
      input int unsigned spray_base,
      input int unsigned dry_cyc,
      input int unsigned dis_small,
      input int unsigned dis_large
   );
      int unsigned d;
      d = 1;
      case (st)
         ST_SPRAYING:  d = spray_base * (mode + 1);
         ST_DRYING:    d = dry_cyc;
         ST_DISCHARGE: d = de_ur ? dis_large : dis_small;
         default:      d = 1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/toilet_core_param_if.sv
// Register-file / actuator bundle between the register block (master) and the
// sequencing core (slave).
interface toilet_core_param_if #(
   parameter int MODE_W = 2,
   parameter int CNT_W  = 16
);
   logic              reg_user_en;
   logic              reg_toilet_using;
   logic              reg_spray_en;
   logic              reg_sp_dr_auto_en;
   logic [MODE_W-1:0] reg_spray_mode;
   logic              reg_auto_dis_en;
   logic              reg_de_ur;
   logic              reg_flush_req;
   logic              warm_en;

   logic              warm_up_on;
   logic              open_toilet_lid;
   logic              led_using;
   logic              spray_an;
   logic              user_flushes;
   logic              dis_de;
   logic              count_spray_done;
   logic              count_drying_done;
   logic              count_dis_done;
   logic              stt_ready;
   logic              stt_using;
   logic              stt_spraying;
   logic              stt_drying;
   logic              stt_discharge;
   logic [CNT_W-1:0]  cnt_val;

   modport master (
      output reg_user_en, reg_toilet_using, reg_spray_en, reg_sp_dr_auto_en,
             reg_spray_mode, reg_auto_dis_en, reg_de_ur, reg_flush_req, warm_en,
      input  warm_up_on, open_toilet_lid, led_using, spray_an, user_flushes, dis_de,
             count_spray_done, count_drying_done, count_dis_done,
             stt_ready, stt_using, stt_spraying, stt_drying, stt_discharge, cnt_val
   );

   modport slave (
      input  reg_user_en, reg_toilet_using, reg_spray_en, reg_sp_dr_auto_en,
             reg_spray_mode, reg_auto_dis_en, reg_de_ur, reg_flush_req, warm_en,
      output warm_up_on, open_toilet_lid, led_using, spray_an, user_flushes, dis_de,
             count_spray_done, count_drying_done, count_dis_done,
             stt_ready, stt_using, stt_spraying, stt_drying, stt_discharge, cnt_val
   );

endinterface

// File: rtl/toilet_dur_timer.sv
// Generic duration timer: counts while enabled, flags the last cycle of a
// DUR-cycle interval, and clears on request.
module toilet_dur_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] dur,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_reg <= '0;
      else if (clr)
         cnt_reg <= '0;
      else if (en)
         cnt_reg <= cnt_reg + CNT_W'(1);
   end

   assign cnt  = cnt_reg;
   assign done = en && (cnt_reg == dur - CNT_W'(1));

endmodule

// File: rtl/toilet_core_param.sv
// Smart-toilet session sequencer: READY/USING/SPRAYING/DRYING/DISCHARGE flow
// with per-mode spray length, selectable discharge volume and one shared timer.
module toilet_core_param
   import toilet_pkg::*;
#(
   parameter int          CNT_W      = 16,
   parameter int          MODE_W     = 2,
   parameter int unsigned SPRAY_BASE = DEF_SPRAY_BASE,
   parameter int unsigned DRY_CYC    = DEF_DRY_CYC,
   parameter int unsigned DIS_SMALL  = DEF_DIS_SMALL,
   parameter int unsigned DIS_LARGE  = DEF_DIS_LARGE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   toilet_core_param_if.slave   bus
);

   localparam longint unsigned SPRAY_MAX = 64'(SPRAY_BASE) << MODE_W;
   localparam longint unsigned DIS_MAX   = (DIS_LARGE > DIS_SMALL) ? 64'(DIS_LARGE) : 64'(DIS_SMALL);
   localparam longint unsigned TD_MAX    = (64'(DRY_CYC) > DIS_MAX) ? 64'(DRY_CYC) : DIS_MAX;
   localparam longint unsigned DUR_MAX   = (SPRAY_MAX > TD_MAX) ? SPRAY_MAX : TD_MAX;
   localparam longint unsigned CNT_LIM   = 64'd1 << CNT_W;

   generate
      if (SPRAY_BASE == 0 || DRY_CYC == 0 || DIS_SMALL == 0 || DIS_LARGE == 0 ||
          DUR_MAX >= CNT_LIM) begin : g_dur_check
         $error("toilet_core_param: every duration must be >= 1 and fit in CNT_W bits");
      end
   endgenerate

   state_t            state_reg, state_next;
   state_t            leave_st;
   logic [MODE_W-1:0] mode_reg;
   logic              de_ur_reg;
   logic              lid_reg;
   logic              tmr_clr, tmr_en, tmr_done;
   logic [CNT_W-1:0]  tmr_dur, tmr_cnt;

   assign leave_st = bus.reg_auto_dis_en ? ST_DISCHARGE : ST_READY;
   assign tmr_en   = (state_reg == ST_SPRAYING) || (state_reg == ST_DRYING) ||
                     (state_reg == ST_DISCHARGE);
   assign tmr_clr  = (state_next != state_reg);
   assign tmr_dur  = CNT_W'(dur_sel(state_reg, 32'(mode_reg), de_ur_reg,
                                    SPRAY_BASE, DRY_CYC, DIS_SMALL, DIS_LARGE));

   toilet_dur_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .dur     (tmr_dur),
      .cnt     (tmr_cnt),
      .done    (tmr_done)
   );

   // The lid is registered so that reset forces it low regardless of reg_user_en.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_READY;
         lid_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         lid_reg   <= (state_next == ST_READY) ? bus.reg_user_en : 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_reg  <= '0;
         de_ur_reg <= 1'b0;
      end else begin
         if (state_reg != ST_SPRAYING && state_next == ST_SPRAYING)
            mode_reg <= bus.reg_spray_mode;
         if (state_reg != ST_DISCHARGE && state_next == ST_DISCHARGE)
            de_ur_reg <= bus.reg_de_ur;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_READY:
            if (bus.reg_user_en && bus.reg_toilet_using)
               state_next = ST_USING;
         ST_USING:
            if (!bus.reg_user_en)
               state_next = leave_st;
            else if (bus.reg_spray_en)
               state_next = ST_SPRAYING;
            else if (bus.reg_flush_req)
               state_next = ST_DISCHARGE;
            else if (!bus.reg_toilet_using && bus.reg_auto_dis_en)
               state_next = ST_DISCHARGE;
         // A user leaving outranks completion; completion outranks a late spray release.
         ST_SPRAYING:
            if (!bus.reg_user_en)
               state_next = leave_st;
            else if (tmr_done)
               state_next = bus.reg_sp_dr_auto_en ? ST_DRYING : ST_USING;
            else if (!bus.reg_spray_en)
               state_next = ST_USING;
         ST_DRYING:
            if (!bus.reg_user_en)
               state_next = leave_st;
            else if (tmr_done)
               state_next = ST_USING;
         ST_DISCHARGE:
            if (tmr_done)
               state_next = bus.reg_user_en ? ST_USING : ST_READY;
         default:
            state_next = ST_READY;
      endcase
   end

   always_comb begin
      bus.stt_ready         = (state_reg == ST_READY);
      bus.stt_using         = (state_reg == ST_USING);
      bus.stt_spraying      = (state_reg == ST_SPRAYING);
      bus.stt_drying        = (state_reg == ST_DRYING);
      bus.stt_discharge     = (state_reg == ST_DISCHARGE);
      bus.led_using         = (state_reg != ST_READY);
      bus.spray_an          = (state_reg == ST_SPRAYING);
      bus.user_flushes      = (state_reg == ST_DISCHARGE);
      bus.dis_de            = (state_reg == ST_DISCHARGE) && de_ur_reg;
      bus.open_toilet_lid   = lid_reg;
      bus.warm_up_on        = bus.warm_en && ((state_reg == ST_USING) ||
                              (state_reg == ST_SPRAYING) || (state_reg == ST_DRYING));
      bus.count_spray_done  = (state_reg == ST_SPRAYING)  && tmr_done;
      bus.count_drying_done = (state_reg == ST_DRYING)    && tmr_done;
      bus.count_dis_done    = (state_reg == ST_DISCHARGE) && tmr_done;
      bus.cnt_val           = tmr_cnt;
   end

endmodule

// File: tb/tb_toilet_core_param.sv
// Scoreboard bench for toilet_core_param: each state change is checked against
// the expected next state and the dwell/actuator statistics of the state left.
module tb_toilet_core_param;

   localparam logic [4:0] R = 5'b00001;
   localparam logic [4:0] U = 5'b00010;
   localparam logic [4:0] S = 5'b00100;
   localparam logic [4:0] D = 5'b01000;
   localparam logic [4:0] X = 5'b10000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   toilet_core_param_if #(.MODE_W(2), .CNT_W(16)) tif ();

   toilet_core_param dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (tif)
   );

   typedef struct {
      logic [4:0] st;
      int         dwell;
      logic [2:0] pm;
      int         np;
      int         sp;
      int         fl;
      int         dd;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   logic [4:0] st_vec;
   assign st_vec = {tif.stt_discharge, tif.stt_drying, tif.stt_spraying,
                    tif.stt_using, tif.stt_ready};

   task automatic push(input logic [4:0] st, input int dwell, input logic [2:0] pm,
                       input int np, input int sp, input int fl, input int dd);
      exp_t e;
      e.st = st; e.dwell = dwell; e.pm = pm; e.np = np;
      e.sp = sp; e.fl = fl; e.dd = dd;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_st(input logic [4:0] mask, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (st_vec != mask && n < budget);
      if (st_vec != mask) begin
         tests++;
         fails++;
         $display("FAIL wait_state: got %b expected %b after %0d cycles", st_vec, mask, n);
      end
   endtask

   // Monitor: on every state change, pop one expectation and compare.
   logic [4:0] prev_st = 5'b00001;
   logic [4:0] mon_st;
   logic [2:0] m_pm = 3'b000;
   int         m_dwell = 0, m_np = 0, m_sp = 0, m_fl = 0, m_dd = 0;
   exp_t       mon_e;

   always @(negedge clk) begin
      mon_st = st_vec;
      if (mon_st != prev_st) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_transition: got %b from %b, expected none", mon_st, prev_st);
         end else begin
            mon_e = exp_q.pop_front();
            tests++;
            if (mon_st != mon_e.st) begin
               fails++;
               $display("FAIL trans_state: got %b expected %b", mon_st, mon_e.st);
            end
            if (mon_e.dwell >= 0) begin
               tests++;
               if (m_dwell != mon_e.dwell) begin
                  fails++;
                  $display("FAIL dwell(%b): got %0d expected %0d", prev_st, m_dwell, mon_e.dwell);
               end
            end
            tests++;
            if (m_pm != mon_e.pm || m_np != mon_e.np) begin
               fails++;
               $display("FAIL done_pulses(%b): got mask %b n %0d expected mask %b n %0d",
                        prev_st, m_pm, m_np, mon_e.pm, mon_e.np);
            end
            tests++;
            if (m_sp != mon_e.sp || m_fl != mon_e.fl || m_dd != mon_e.dd) begin
               fails++;
               $display("FAIL actuator_cycles(%b): got spray %0d flush %0d dis_de %0d expected %0d %0d %0d",
                        prev_st, m_sp, m_fl, m_dd, mon_e.sp, mon_e.fl, mon_e.dd);
            end
            $display("[TB] transition %b -> %b dwell %0d checked", prev_st, mon_st, m_dwell);
         end
         m_dwell = 0; m_np = 0; m_sp = 0; m_fl = 0; m_dd = 0; m_pm = 3'b000;
      end
      m_dwell++;
      m_sp += int'(tif.spray_an);
      m_fl += int'(tif.user_flushes);
      m_dd += int'(tif.dis_de);
      if (tif.count_spray_done)  begin m_pm[0] = 1'b1; m_np++; end
      if (tif.count_drying_done) begin m_pm[1] = 1'b1; m_np++; end
      if (tif.count_dis_done)    begin m_pm[2] = 1'b1; m_np++; end
      prev_st = mon_st;
   end

   function automatic logic [8:0] out_vec();
      return {tif.warm_up_on, tif.open_toilet_lid, tif.led_using, tif.spray_an,
              tif.user_flushes, tif.dis_de, tif.count_spray_done,
              tif.count_drying_done, tif.count_dis_done};
   endfunction

   initial begin
      tif.reg_user_en = 0; tif.reg_toilet_using = 0; tif.reg_spray_en = 0;
      tif.reg_sp_dr_auto_en = 1; tif.reg_spray_mode = 2'd0; tif.reg_auto_dis_en = 0;
      tif.reg_de_ur = 0; tif.reg_flush_req = 0; tif.warm_en = 0;

      // Reset state
      cyc(3);
      chk("reset_stt", st_vec, R);
      chk("reset_outs", out_vec(), 0);
      chk("reset_cnt", tif.cnt_val, 0);
      reset_n = 1;
      cyc(1);

      // Basic session: arrive, sit, spray mode 0, auto-dry
      tif.reg_user_en = 1;
      cyc(5);
      chk("lid_follows_user", tif.open_toilet_lid, 1);
      chk("ready_until_seated", st_vec, R);
      tif.reg_toilet_using = 1;
      push(U, -1, 3'b000, 0, 0, 0, 0);
      cyc(1);
      chk("using_one_cycle", tif.stt_using, 1);
      tif.warm_en = 1;
      #1;
      chk("warm_in_using", tif.warm_up_on, 1);
      tif.reg_spray_en = 1;
      push(S, -1, 3'b000, 0, 0, 0, 0);
      push(D, 100, 3'b001, 1, 100, 0, 0);
      push(U, 80, 3'b010, 1, 0, 0, 0);
      wait_st(S, 4);
      chk("spray_cnt_start", tif.cnt_val, 0);
      wait_st(D, 200);
      tif.reg_spray_en = 0;
      wait_st(U, 200);

      // Mode scaling: mode 3 sprays 400 cycles
      tif.reg_spray_mode = 2'd3;
      tif.reg_spray_en = 1;
      push(S, -1, 3'b000, 0, 0, 0, 0);
      push(D, 400, 3'b001, 1, 400, 0, 0);
      push(U, 80, 3'b010, 1, 0, 0, 0);
      wait_st(D, 500);
      tif.reg_spray_en = 0;
      wait_st(U, 200);

      // Spray abort at cycle 30
      tif.reg_spray_mode = 2'd0;
      tif.reg_spray_en = 1;
      push(S, -1, 3'b000, 0, 0, 0, 0);
      push(U, 30, 3'b000, 0, 30, 0, 0);
      wait_st(S, 4);
      cyc(29);
      chk("abort_cnt", tif.cnt_val, 29);
      tif.reg_spray_en = 0;
      wait_st(U, 4);

      // Spray without auto-dry
      tif.reg_sp_dr_auto_en = 0;
      tif.reg_spray_en = 1;
      push(S, -1, 3'b000, 0, 0, 0, 0);
      push(U, 100, 3'b001, 1, 100, 0, 0);
      wait_st(U, 200);
      tif.reg_spray_en = 0;
      tif.reg_sp_dr_auto_en = 1;

      // User leaves, large discharge, de_ur toggled mid-discharge
      tif.reg_de_ur = 1;
      tif.reg_auto_dis_en = 1;
      tif.reg_user_en = 0;
      tif.reg_toilet_using = 0;
      push(X, -1, 3'b000, 0, 0, 0, 0);
      push(R, 60, 3'b100, 1, 0, 60, 60);
      wait_st(X, 4);
      cyc(10);
      tif.reg_de_ur = 0;
      wait_st(R, 100);
      cyc(1);
      chk("lid_closed_empty", tif.open_toilet_lid, 0);

      // Small discharge on leaving
      tif.reg_user_en = 1;
      tif.reg_toilet_using = 1;
      push(U, -1, 3'b000, 0, 0, 0, 0);
      wait_st(U, 4);
      tif.reg_user_en = 0;
      tif.reg_toilet_using = 0;
      push(X, -1, 3'b000, 0, 0, 0, 0);
      push(R, 40, 3'b100, 1, 0, 40, 0);
      wait_st(R, 100);

      // Manual flush, no auto-discharge; then leave without flush
      tif.reg_auto_dis_en = 0;
      tif.reg_user_en = 1;
      tif.reg_toilet_using = 1;
      push(U, -1, 3'b000, 0, 0, 0, 0);
      wait_st(U, 4);
      tif.reg_flush_req = 1;
      push(X, -1, 3'b000, 0, 0, 0, 0);
      push(U, 40, 3'b100, 1, 0, 40, 0);
      wait_st(X, 4);
      tif.reg_flush_req = 0;
      wait_st(U, 100);
      tif.reg_user_en = 0;
      tif.reg_toilet_using = 0;
      push(R, -1, 3'b000, 0, 0, 0, 0);
      wait_st(R, 4);
      cyc(3);

      // Async reset at discharge cycle 20, off the clock edge
      tif.reg_user_en = 1;
      tif.reg_toilet_using = 1;
      push(U, -1, 3'b000, 0, 0, 0, 0);
      wait_st(U, 4);
      tif.reg_de_ur = 1;
      tif.reg_flush_req = 1;
      push(X, -1, 3'b000, 0, 0, 0, 0);
      push(R, 20, 3'b000, 0, 0, 20, 20);
      wait_st(X, 4);
      tif.reg_flush_req = 0;
      cyc(19);
      #3;
      reset_n = 0;
      #1;
      chk("async_rst_stt", st_vec, R);
      chk("async_rst_outs", out_vec(), 0);
      chk("async_rst_cnt", tif.cnt_val, 0);
      tif.reg_user_en = 0;
      tif.reg_toilet_using = 0;
      cyc(2);
      reset_n = 1;
      cyc(10);
      chk("idle_after_reset", st_vec, R);
      tif.reg_user_en = 1;
      tif.reg_toilet_using = 1;
      push(U, -1, 3'b000, 0, 0, 0, 0);
      wait_st(U, 4);
      cyc(2);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
